// File: rtl/audio_led_pio_pkg.sv
// audio_led_pio_pkg: register map shared by the LED PIO top level and its bench.
//   ADDR_W           - width of the word address bus
//   ADDR_*           - word offsets of the slave registers (1 and 7 are reserved)
package audio_led_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_EN   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUT_STATUS = 3'd6;

endpackage

// File: rtl/audio_led_blink_timer.sv
// audio_led_blink_timer: prescaler that toggles a shared blink phase every
// PERIOD+1 cycles.
//   clk         in   system clock
//   reset       in   synchronous active-high reset (cnt = DEFAULT_PERIOD, phase = 1)
//   load        in   PERIOD register write this cycle: cnt <= load_value, phase held
//   load_value  in   reload value; the top drives the current PERIOD here, or the
//                    new write data while load is high, so the period lives in one place
//   phase       out  blink phase
module audio_led_blink_timer #(
    parameter int unsigned PRESCALE_W     = 24,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd12_499_999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] load_value,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= DEFAULT_PERIOD[PRESCALE_W-1:0];
            phase <= 1'b1;
        end else if (load) begin
            // a PERIOD write wins over a reload that would have happened this cycle
            cnt <= load_value;
        end else if (cnt == '0) begin
            cnt   <= load_value;
            phase <= ~phase;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/audio_led_pio.sv
// audio_led_pio: Avalon-MM LED output port with atomic set/clear and optional
// per-bit hardware blinking. Zero wait states, read latency 0.
//   clk, reset         system clock, synchronous active-high reset
//   address            word register index
//   chipselect,write_n write strobe = chipselect & ~write_n
//   writedata          write data (bits above register width ignored)
//   readdata           combinational read mux, zero-extended
//   out_port           LED drive, registered state only
// Build option: define AUDIO_LED_PIO_BLINK_EN to include the blink timer,
// BLINK_EN and PERIOD; otherwise offsets 2/3 are reserved and out_port = DATA.
module audio_led_pio
    import audio_led_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter int unsigned PRESCALE_W     = 24,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd12_499_999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] data_q;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE[DATA_WIDTH-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_q <= wdata;
                ADDR_OUTSET:   data_q <= data_q | wdata;
                ADDR_OUTCLEAR: data_q <= data_q & ~wdata;
                default:       ;
            endcase
        end
    end

`ifdef AUDIO_LED_PIO_BLINK_EN
    logic [DATA_WIDTH-1:0] blink_en_q;
    logic [PRESCALE_W-1:0] period_q;
    logic                  period_wr;
    logic                  phase;
    logic                  unused_ok;

    assign period_wr = wr_en && (address == ADDR_PERIOD);
    assign unused_ok = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_en_q <= '0;
            period_q   <= DEFAULT_PERIOD[PRESCALE_W-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_BLINK_EN: blink_en_q <= wdata;
                ADDR_PERIOD:   period_q   <= writedata[PRESCALE_W-1:0];
                default:       ;
            endcase
        end
    end

    audio_led_blink_timer #(
        .PRESCALE_W     (PRESCALE_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (period_wr),
        .load_value (period_wr ? writedata[PRESCALE_W-1:0] : period_q),
        .phase      (phase)
    );

    // blinking bits are gated by phase; a blinking bit with DATA=0 stays dark
    assign out_port = data_q & (~blink_en_q | {DATA_WIDTH{phase}});
`else
    logic unused_ok;

    assign unused_ok = ^{writedata, 32'(PRESCALE_W), DEFAULT_PERIOD};
    assign out_port  = data_q;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata[DATA_WIDTH-1:0] = data_q;
`ifdef AUDIO_LED_PIO_BLINK_EN
            ADDR_BLINK_EN:   readdata[DATA_WIDTH-1:0] = blink_en_q;
            ADDR_PERIOD:     readdata[PRESCALE_W-1:0] = period_q;
`endif
            ADDR_OUT_STATUS: readdata[DATA_WIDTH-1:0] = out_port;
            default:         readdata = '0;
        endcase
    end

endmodule
